// File: rtl/snake_dir_ctrl.sv
// Snake heading controller: button edge detection, turn validation, turn queue, IDLE/RUN/PAUSED/OVER FSM.
// Optional drop statistics output enabled by defining SNAKE_DIR_STATS_EN.
module snake_dir_ctrl #(
   parameter logic [1:0] INIT_DIR = 2'b11,
   parameter int         QDEPTH   = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_pause,
   input  logic       move_tick,
   input  logic       game_over,
   output logic [1:0] dir,
   output logic       dir_strobe,
   output logic       running,
   output logic [1:0] state,
   output logic [2:0] q_count
`ifdef SNAKE_DIR_STATS_EN
   ,
   output logic [7:0] drop_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RUN    = 2'b01,
      S_PAUSED = 2'b10,
      S_OVER   = 2'b11
   } state_t;

   state_t     r_state;
   logic [1:0] r_dir;
   logic [1:0] r_last_req;
   logic       r_strobe;
   logic       r_running;
   logic [2:0] r_count;
   logic [4:0] r_prev;
   logic [4:0] r_press;
   logic [1:0] r_q [QDEPTH];

   logic [4:0] w_level;
   logic [1:0] w_req_d;
   logic       w_dir_vld;
   logic       w_pause;
   logic       w_accept;
   logic       w_run_act;
   logic       w_pop;
   logic       w_push;
   logic [2:0] w_wr_idx;
   logic [1:0] w_q_shift [QDEPTH];

   // Bit index equals the direction code, so priority is simply lowest index first.
   assign w_level   = {btn_pause, btn_right, btn_left, btn_down, btn_up};
   assign w_dir_vld = |r_press[3:0];
   assign w_pause   = r_press[4];
   assign w_req_d   = r_press[0] ? 2'b00 :
                      r_press[1] ? 2'b01 :
                      r_press[2] ? 2'b10 : 2'b11;
   assign w_accept  = w_dir_vld && (w_req_d[1] != r_last_req[1]);
   assign w_run_act = (r_state == S_RUN) && !game_over;
   assign w_pop     = w_run_act && move_tick && (r_count != 3'd0);
   assign w_push    = w_run_act && w_accept && ((r_count < 3'(QDEPTH)) || w_pop);
   assign w_wr_idx  = r_count - {2'b00, w_pop};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prev  <= 5'b11111;
         r_press <= 5'b00000;
      end else begin
         r_prev  <= w_level;
         r_press <= w_level & ~r_prev;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < QDEPTH; gi++) begin : g_shift
         if (gi < QDEPTH - 1) begin : g_mid
            assign w_q_shift[gi] = r_q[gi+1];
         end else begin : g_tail
            assign w_q_shift[gi] = r_q[gi];
         end
      end
   endgenerate

   // Head lives at index 0; a pop shifts down and a simultaneous push lands one slot lower.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < QDEPTH; i++) r_q[i] <= 2'b00;
      end else begin
         for (int i = 0; i < QDEPTH; i++) begin
            if (w_push && (w_wr_idx == 3'(i)))
               r_q[i] <= w_req_d;
            else if (w_pop)
               r_q[i] <= w_q_shift[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_dir      <= INIT_DIR;
         r_last_req <= INIT_DIR;
         r_strobe   <= 1'b0;
         r_running  <= 1'b0;
         r_count    <= 3'd0;
      end else begin
         r_strobe <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state    <= S_RUN;
                  r_running  <= 1'b1;
                  r_dir      <= w_req_d;
                  r_last_req <= w_req_d;
                  r_strobe   <= 1'b1;
               end
            end
            S_RUN: begin
               if (game_over) begin
                  r_state    <= S_OVER;
                  r_running  <= 1'b0;
                  r_count    <= 3'd0;
                  r_last_req <= r_dir;
               end else begin
                  if (w_pause) begin
                     r_state   <= S_PAUSED;
                     r_running <= 1'b0;
                  end
                  if (w_pop) begin
                     r_dir    <= r_q[0];
                     r_strobe <= (r_q[0] != r_dir);
                  end
                  if (w_push) r_last_req <= w_req_d;
                  r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
               end
            end
            S_PAUSED: begin
               if (game_over) begin
                  r_state    <= S_OVER;
                  r_count    <= 3'd0;
                  r_last_req <= r_dir;
               end else if (w_pause) begin
                  r_state   <= S_RUN;
                  r_running <= 1'b1;
               end
            end
            default: begin
               if (w_pause) begin
                  r_state    <= S_IDLE;
                  r_dir      <= INIT_DIR;
                  r_last_req <= INIT_DIR;
                  r_strobe   <= (r_dir != INIT_DIR);
               end
            end
         endcase
      end
   end

`ifdef SNAKE_DIR_STATS_EN
   logic [7:0] r_drop_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_drop_cnt <= 8'd0;
      end else if ((r_state == S_OVER) && w_pause) begin
         r_drop_cnt <= 8'd0;
      end else if (w_run_act && w_dir_vld && !w_push && (r_drop_cnt != 8'hFF)) begin
         r_drop_cnt <= r_drop_cnt + 8'd1;
      end
   end

   assign drop_cnt = r_drop_cnt;
`endif

   assign dir        = r_dir;
   assign dir_strobe = r_strobe;
   assign running    = r_running;
   assign state      = r_state;
   assign q_count    = r_count;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Self-checking bench for snake_dir_ctrl: directed scenarios with literal expectations,
// then randomized buttons/ticks/game_over/reset compared every cycle against a queue-based model.
module tb_snake_dir_ctrl;
   localparam logic [1:0] INIT = 2'b11;
   localparam int         QD   = 2;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       move_tick = 1'b0;
   logic       game_over = 1'b0;
   logic [4:0] btn = 5'b00000;   // [0]=up [1]=down [2]=left [3]=right [4]=pause
   logic [1:0] dir;
   logic       dir_strobe;
   logic       running;
   logic [1:0] state;
   logic [2:0] q_count;
`ifdef SNAKE_DIR_STATS_EN
   logic [7:0] drop_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   snake_dir_ctrl #(.INIT_DIR(INIT), .QDEPTH(QD)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .btn_up     (btn[0]),
      .btn_down   (btn[1]),
      .btn_left   (btn[2]),
      .btn_right  (btn[3]),
      .btn_pause  (btn[4]),
      .move_tick  (move_tick),
      .game_over  (game_over),
      .dir        (dir),
      .dir_strobe (dir_strobe),
      .running    (running),
      .state      (state),
      .q_count    (q_count)
`ifdef SNAKE_DIR_STATS_EN
      ,
      .drop_cnt   (drop_cnt)
`endif
   );

   task automatic chk(string nm, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: states as integers 0..3, turn queue as an SV queue.
   int         m_state;
   logic [1:0] m_dir;
   logic       m_strobe;
   logic [1:0] m_q[$];
   int         m_drop;
   logic [4:0] m_prev;
   logic [4:0] m_press;

   always @(posedge clk or negedge reset_n) begin : model
      logic [1:0] d, old_dir, lr;
      bit         dv, pz, pop, push;
      if (!reset_n) begin
         m_state  = 0;
         m_dir    = INIT;
         m_strobe = 1'b0;
         m_q.delete();
         m_drop   = 0;
         m_prev   = 5'b11111;
         m_press  = 5'b00000;
      end else begin
         old_dir = m_dir;
         dv = 1'b0;
         d  = 2'b00;
         for (int i = 3; i >= 0; i--) begin
            if (m_press[i]) begin
               dv = 1'b1;
               d  = 2'(i);
            end
         end
         pz = m_press[4];
         lr = (m_q.size() > 0) ? m_q[$] : m_dir;
         case (m_state)
            0: if (dv && (d[1] != lr[1])) begin
                  m_state = 1;
                  m_dir   = d;
               end
            1: if (game_over) begin
                  m_state = 3;
                  m_q.delete();
               end else begin
                  pop  = move_tick && (m_q.size() > 0);
                  push = 1'b0;
                  if (dv) begin
                     if ((d[1] != lr[1]) && ((m_q.size() < QD) || pop)) push = 1'b1;
                     else if (m_drop < 255) m_drop++;
                  end
                  if (pop) m_dir = m_q.pop_front();
                  if (push) m_q.push_back(d);
                  if (pz) m_state = 2;
               end
            2: if (game_over) begin
                  m_state = 3;
                  m_q.delete();
               end else if (pz) begin
                  m_state = 1;
               end
            default: if (pz) begin
                  m_state = 0;
                  m_dir   = INIT;
                  m_drop  = 0;
               end
         endcase
         m_strobe = (m_dir != old_dir);
         m_press  = btn & ~m_prev;
         m_prev   = btn;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("dir", int'(dir), int'(m_dir));
         chk("dir_strobe", int'(dir_strobe), int'(m_strobe));
         chk("running", int'(running), (m_state == 1) ? 1 : 0);
         chk("state", int'(state), m_state);
         chk("q_count", int'(q_count), m_q.size());
`ifdef SNAKE_DIR_STATS_EN
         chk("drop_cnt", int'(drop_cnt), m_drop);
`endif
      end
   end

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Level high for one cycle; the press takes effect at the second edge.
   task automatic press(logic [4:0] mask);
      btn = mask;
      cyc(1);
      btn = 5'b00000;
      cyc(1);
   endtask

   task automatic tick();
      move_tick = 1'b1;
      cyc(1);
      move_tick = 1'b0;
   endtask

   initial begin
      btn[3] = 1'b1;
      #1 reset_n = 1'b0;
      cmp_en = 1'b1;
      #21 reset_n = 1'b1;
      cyc(3);
      chk("rst_state", int'(state), 0);
      chk("rst_dir", int'(dir), 3);
      chk("rst_strobe", int'(dir_strobe), 0);
      chk("rst_qcount", int'(q_count), 0);
      btn = 5'b00000;
      cyc(2);

      press(5'b00001);                       // up from IDLE
      chk("idle_up_state", int'(state), 1);
      chk("idle_up_dir", int'(dir), 0);
      chk("idle_up_strobe", int'(dir_strobe), 1);
      cyc(1);
      chk("idle_up_strobe_off", int'(dir_strobe), 0);
      press(5'b00010);                       // down: reverse, rejected
      chk("reject_q", int'(q_count), 0);
      chk("reject_dir", int'(dir), 0);

      press(5'b01000);                       // right, then commit it
      tick();
      chk("to_right_dir", int'(dir), 3);
      press(5'b00001);
      press(5'b00100);
      press(5'b00010);                       // queue full: dropped
      chk("full_q", int'(q_count), 2);
      chk("full_dir", int'(dir), 3);
`ifdef SNAKE_DIR_STATS_EN
      chk("drop_cnt_lit", int'(drop_cnt), 2);
`endif
      tick();
      chk("pop1_dir", int'(dir), 0);
      chk("pop1_strobe", int'(dir_strobe), 1);
      tick();
      chk("pop2_dir", int'(dir), 2);
      chk("pop2_q", int'(q_count), 0);

      press(5'b00001);
      press(5'b00100);
      btn = 5'b00010;                        // valid press and tick in the same cycle while full
      cyc(1);
      btn = 5'b00000;
      move_tick = 1'b1;
      cyc(1);
      move_tick = 1'b0;
      chk("pushpop_q", int'(q_count), 2);
      chk("pushpop_dir", int'(dir), 0);

      press(5'b10000);
      chk("paused_state", int'(state), 2);
      chk("paused_running", int'(running), 0);
      tick(); tick(); tick();
      chk("paused_dir", int'(dir), 0);
      chk("paused_q", int'(q_count), 2);
      press(5'b10000);
      chk("resume_state", int'(state), 1);
      tick();
      chk("resume_pop_dir", int'(dir), 2);
      chk("resume_pop_q", int'(q_count), 1);

      press(5'b00100);
      chk("pre_over_q", int'(q_count), 2);
      game_over = 1'b1;
      cyc(1);
      game_over = 1'b0;
      chk("over_state", int'(state), 3);
      chk("over_q", int'(q_count), 0);
      chk("over_dir", int'(dir), 2);
      press(5'b10000);
      chk("restart_state", int'(state), 0);
      chk("restart_dir", int'(dir), 3);
      chk("restart_strobe", int'(dir_strobe), 1);

      press(5'b00001);
      press(5'b00100);
      chk("pre_areset_q", int'(q_count), 1);
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      chk("areset_state", int'(state), 0);
      chk("areset_dir", int'(dir), 3);
      chk("areset_q", int'(q_count), 0);
      chk("areset_running", int'(running), 0);
      chk("areset_strobe", int'(dir_strobe), 0);
      cyc(1);
      reset_n = 1'b1;
      cyc(1);

      for (int c = 0; c < 4000; c++) begin
         for (int b = 0; b < 5; b++) begin
            if ($urandom_range(0, 3) == 0) btn[b] = ~btn[b];
         end
         move_tick = ($urandom_range(0, 3) == 0);
         game_over = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 799) == 0) begin
            reset_n = 1'b0;
            #2 reset_n = 1'b1;
         end
         cyc(1);
      end
      move_tick = 1'b0;
      game_over = 1'b0;
      cyc(2);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
